wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Upstream stage for the 8-bit Sklansky datapath. Accepts operand byte pairs LSB-first over a valid/ready
//  stream, adds each pair with the carry from the previous byte, and emits sum bytes plus final carry/overflow.
//  Extends the 8-bit adder to multi-byte words of up to MAX_BYTES bytes without widening the pad interface.
// PARAMETERS
//  MAX_BYTES  4  max bytes per word; in_last is forced on byte MAX_BYTES (>=2, <=16)
//  OBUF_DEPTH 2  output buffer entries (fixed 2: skid pair)
// PORTS
//  clock      in   1  single clock, rising edge
//  reset_n    in   1  asynchronous active-low reset
//  enable     in   1  pad enable; low = stall (no accept, no emit, state held)
//  in_valid   in   1  operand byte pair present
//  in_ready   out  1  block can accept this cycle
//  in_a       in   8  operand A byte
//  in_b       in   8  operand B byte
//  in_last    in   1  byte is the MSB byte of the word
//  out_valid  out  1  sum byte present
//  out_ready  in   1  consumer accepts
//  out_sum    out  8  sum byte
//  out_last   out  1  sum byte is word MSB
//  out_carry  out  1  unsigned carry-out of word; valid only with out_last, else 0
//  out_ovf    out  1  signed overflow of word; valid only with out_last, else 0
//  busy       out  1  mid-word (at least one byte of current word accepted, last not yet)
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0 except in_ready=0; carry=0, byte count=0, FSM=IDLE, buffer empty.
//  First cycle after release: in_ready=1 if enable=1.
//  Accept: in_valid & in_ready & enable. Emit: out_valid & out_ready & enable.
//  in_ready = enable & (buffer count < 2). Independent of in_valid (no comb. path valid->ready).
//  Byte sum: {c_out, s} = in_a + in_b + carry. carry<=c_out on accept of non-last byte; 0 on last.
//  Overflow: ovf = c_out XOR carry-into-bit7 of the last byte only.
//  Effective last = in_last | (byte count == MAX_BYTES-1). Count wraps to 0 after last.
//  Latency: accepted byte appears on out_* next cycle (1 cycle) if buffer was empty.
//  Buffer: 2-entry FIFO {sum,last,carry,ovf}; out_* driven from head register (registered outputs).
//   Simultaneous accept+emit with count=2 impossible (in_ready=0); with count=1 -> count stays 1.
//   Emit with count 0 never occurs (out_valid=0).
//  FSM (word tracking): IDLE -accept non-last-> RUN; IDLE -accept last-> IDLE (1-byte word, carry=0 in).
//   RUN -accept non-last-> RUN; RUN -accept last-> IDLE. busy = (state==RUN).
//  enable=0: no state change; out_valid holds its value, handshakes ignored.
//  Reset mid-word: partial word discarded, buffer flushed, no out_last emitted.
//  Arithmetic unsigned mod 2^8 per byte; no saturation.
// STRUCTURE
//  Package wide_add_pkg: BYTE_W=8, MAX_BYTES_DEF=4, typedef obuf_entry_t {sum[7:0],last,carry,ovf},
//   typedef enum {IDLE,RUN} seq_state_t.
//  Sub-module sklansky_adder_8bit_ci: combinational 8-bit Sklansky prefix adder (generate/propagate,
//   black/gray cells) with cin feeding bit-0 gray cell and cout from a level-4 gray cell; also exports c7.
//  Top: FSM + byte counter + carry reg + 2-entry buffer around one sklansky_adder_8bit_ci instance.
// TESTING
//  1-byte word: a=0xFF,b=0x01,last=1 -> next cycle sum=0x00,last=1,carry=1,ovf=0.
//  2-byte carry chain: (0xFF,0x01),(0x00,0x00,last) -> sums 0x00 then 0x01, carry=0 on last.
//  Signed overflow: (0x7F,0x01,last) -> sum=0x80, ovf=1, carry=0; (0x80,0x80,last) -> 0x00, ovf=1, carry=1.
//  Back-pressure: out_ready=0, send 3 bytes -> 2 accepted, in_ready=0; release -> order preserved, none lost.
//  Forced last: MAX_BYTES=4, 4 bytes in_last=0 -> 4th output out_last=1; 5th byte starts fresh, carry-in 0.
//  Async reset mid-word after 2 bytes -> outputs 0 immediately; next word (0x01,0x01,last) -> 0x02, carry=0.

Source files
------------

// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared types and constants for the wide add sequencer
`timescale 1ns/1ps
package wide_add_pkg;
  localparam int BYTE_W        = 8;
  localparam int MAX_BYTES_DEF = 4;

  // One output buffer slot; carry/ovf are only ever set together with last.
  typedef struct packed {
    logic [BYTE_W-1:0] sum;
    logic              last;
    logic              carry;
    logic              ovf;
  } obuf_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;
endpackage

// File: rtl/sklansky_adder_8bit_ci.sv
// rtl/sklansky_adder_8bit_ci.sv - combinational 8-bit Sklansky prefix adder with carry-in
`timescale 1ns/1ps
module sklansky_adder_8bit_ci
  import wide_add_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum,
  output logic              o_cout,
  output logic              o_c7
);
  logic [7:0] w_g, w_p, w_c;
  // Level 1: cin folded into bit 0 so every prefix reaching bit 0 is a gray cell
  logic w_g0n;
  // Level 2 (span 1)
  logic w_g1n, w_g32, w_p32, w_g54, w_p54, w_g76, w_p76;
  // Level 3 (span 2)
  logic w_g2n, w_g3n, w_g64, w_p64, w_g74, w_p74;
  // Level 4 (span 4)
  logic w_g4n, w_g5n, w_g6n, w_g7n;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_g0n = w_g[0] | (w_p[0] & i_cin);

  assign w_g1n = w_g[1] | (w_p[1] & w_g0n);
  assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
  assign w_p32 = w_p[3] & w_p[2];
  assign w_g54 = w_g[5] | (w_p[5] & w_g[4]);
  assign w_p54 = w_p[5] & w_p[4];
  assign w_g76 = w_g[7] | (w_p[7] & w_g[6]);
  assign w_p76 = w_p[7] & w_p[6];

  assign w_g2n = w_g[2] | (w_p[2] & w_g1n);
  assign w_g3n = w_g32  | (w_p32  & w_g1n);
  assign w_g64 = w_g[6] | (w_p[6] & w_g54);
  assign w_p64 = w_p[6] & w_p54;
  assign w_g74 = w_g76  | (w_p76  & w_g54);
  assign w_p74 = w_p76  & w_p54;

  assign w_g4n = w_g[4] | (w_p[4] & w_g3n);
  assign w_g5n = w_g54  | (w_p54  & w_g3n);
  assign w_g6n = w_g64  | (w_p64  & w_g3n);
  assign w_g7n = w_g74  | (w_p74  & w_g3n);

  assign w_c    = {w_g6n, w_g5n, w_g4n, w_g3n, w_g2n, w_g1n, w_g0n, i_cin};
  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_g7n;
  assign o_c7   = w_g6n;
endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - byte-serial multi-byte adder with 2-entry skid output buffer
`timescale 1ns/1ps
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int MAX_BYTES  = MAX_BYTES_DEF,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              busy
);
  localparam int CNT_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic              r_carry;
  obuf_entry_t       r_head;
  obuf_entry_t       r_tail;
  logic [1:0]        r_count;

  logic              w_acc;
  logic              w_emit;
  logic              w_eff_last;
  logic [BYTE_W-1:0] w_sum;
  logic              w_cout;
  logic              w_c7;
  obuf_entry_t       w_entry;

  // reset_n gating keeps in_ready low while reset is held
  assign in_ready   = reset_n & enable & (r_count < 2'(OBUF_DEPTH));
  assign w_acc      = in_valid & in_ready;
  assign w_emit     = out_valid & out_ready & enable;
  assign w_eff_last = in_last | (r_byte_cnt == CNT_W'(MAX_BYTES - 1));

  sklansky_adder_8bit_ci u_adder (
    .i_a    (in_a),
    .i_b    (in_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_c7   (w_c7)
  );

  // Build the buffer entry; word carry/overflow only reported on the last byte
  always_comb begin
    w_entry.sum   = w_sum;
    w_entry.last  = w_eff_last;
    w_entry.carry = w_eff_last & w_cout;
    w_entry.ovf   = w_eff_last & (w_cout ^ w_c7);
  end

  // Word tracking FSM with byte counter and inter-byte carry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_carry    <= 1'b0;
    end else if (w_acc) begin
      if (w_eff_last) begin
        r_state    <= IDLE;
        r_byte_cnt <= '0;
        r_carry    <= 1'b0;
      end else begin
        r_state    <= RUN;
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        r_carry    <= w_cout;
      end
    end
  end

  // Two-entry output FIFO; head register drives out_* directly
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_acc, w_emit})
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_entry;
          else                 r_tail <= w_entry;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= (r_count == 2'd2) ? r_tail : '0;
          r_count <= r_count - 2'd1;
        end
        2'b11: r_head <= w_entry;
        default: ;
      endcase
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign out_sum   = r_head.sum;
  assign out_last  = r_head.last;
  assign out_carry = r_head.carry;
  assign out_ovf   = r_head.ovf;
  assign busy      = (r_state == RUN);
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - scoreboard bench for wide_add_sequencer
`timescale 1ns/1ps
module tb_wide_add_sequencer;
  localparam int MAXB = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       in_ready, out_valid, out_last, out_carry, out_ovf, busy;
  logic [7:0] out_sum;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [10:0] sb[$];
  logic       m_carry = 1'b0;
  int         m_cnt = 0;
  bit         rnd_on;

  wide_add_sequencer #(.MAX_BYTES(MAXB), .OBUF_DEPTH(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte pair; model the expected output when the handshake is seen
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    logic [8:0] tot;
    logic [7:0] s;
    logic       eff;
    logic       ovf;
    bit         done;
    done = 1'b0;
    eff = 1'b0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clock);
      if (in_ready) begin
        tot = {1'b0, a} + {1'b0, b} + {8'd0, m_carry};
        s   = tot[7:0];
        eff = last || (m_cnt == MAXB - 1);
        ovf = (a[7] == b[7]) && (s[7] != a[7]);
        sb.push_back({s, eff, eff & tot[8], eff & ovf});
        if (eff) begin m_carry = 1'b0; m_cnt = 0; end
        else     begin m_carry = tot[8]; m_cnt++; end
        done = 1'b1;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("accept_within_budget", 32'(done), 32'd1);
    if (done) check("busy_after_accept", 32'(busy), 32'(!eff));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && (sb.size() != 0 || out_valid); cyc++) begin
      @(posedge clock); #1;
    end
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Output monitor: pop and compare each emitted byte
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clock);
      if (reset_n && enable && out_valid && out_ready) begin
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_word", {21'd0, out_sum, out_last, out_carry, out_ovf}, {21'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    enable = 1'b1;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;

    // 1-byte word with carry out, one-cycle latency
    send(8'hFF, 8'h01, 1'b1);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_word", {out_sum, out_last, out_carry, out_ovf}, {8'h00, 1'b1, 1'b1, 1'b0});
    drain();

    // 2-byte carry chain
    send(8'hFF, 8'h01, 1'b0);
    send(8'h00, 8'h00, 1'b1);
    drain();

    // Signed overflow
    send(8'h7F, 8'h01, 1'b1);
    send(8'h80, 8'h80, 1'b1);
    drain();

    // Back-pressure and enable stall
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b0);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    enable = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("stall_out_valid_held", 32'(out_valid), 32'd1);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_busy_held", 32'(busy), 32'd1);
    enable = 1'b1;
    out_ready = 1'b0;
    fork
      send(8'h55, 8'h66, 1'b1);
      begin repeat (3) @(posedge clock); #2 out_ready = 1'b1; end
    join
    drain();

    // Forced last on byte MAXB, next byte starts fresh
    for (int i = 0; i < MAXB; i++) send(8'hFF, 8'h01, 1'b0);
    send(8'h01, 8'h01, 1'b1);
    drain();

    // Async reset mid-word
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    send(8'h56, 8'h78, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    m_carry = 1'b0;
    m_cnt = 0;
    @(posedge clock); #1 reset_n = 1'b1;
    out_ready = 1'b1;
    send(8'h01, 8'h01, 1'b1);
    check("after_rst_word", {out_sum, out_last, out_carry, out_ovf}, {8'h02, 1'b1, 1'b0, 1'b0});
    drain();

    // Random traffic with random back-pressure
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clock);
          #2 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
